// File: rtl/gpioemu_pkg.sv
// Shared definitions for the gpioemu multiplier: default operand width,
// multiplier FSM states and the gpioemu register-file offsets.
package gpioemu_pkg;

    localparam int unsigned GPIOEMU_WIDTH = 24;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } mult_state_e;

    localparam logic [11:0] REG_A1  = 12'h430;
    localparam logic [11:0] REG_A2  = 12'h438;
    localparam logic [11:0] REG_W   = 12'h440;
    localparam logic [11:0] REG_L   = 12'h448;
    localparam logic [11:0] REG_B   = 12'h450;
    localparam logic [11:0] REG_CNT = 12'h458;

endpackage

// File: rtl/gpioemu_mult.sv
// Iterative shift-add unsigned multiplier, WIDTH cycles per product.
// Macro GPIOEMU_MULT_OPCNT_EN builds the 32-bit completed-operation counter.
module gpioemu_mult
    import gpioemu_pkg::*;
#(
    parameter int unsigned WIDTH = GPIOEMU_WIDTH
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product,
    output logic [31:0]          op_count
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    mult_state_e          state_q, state_d;
    logic [WIDTH-1:0]     mcand_q, mcand_d;
    logic [WIDTH-1:0]     mplier_q, mplier_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [2*WIDTH-1:0]   product_q, product_d;
    logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic [2*WIDTH-1:0]   addend;

    assign addend = {{WIDTH{1'b0}}, mcand_q} << bit_cnt_q;

    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path
        // through the case leaves one unassigned and no latch is inferred.
        state_d   = state_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        acc_d     = acc_q;
        product_d = product_q;
        bit_cnt_d = bit_cnt_q;
        done_d    = 1'b0;
        // busy trails the RUN state by one cycle so it drops in the done cycle
        busy_d    = (state_q == ST_RUN);

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    mcand_d   = a;
                    mplier_d  = b;
                    acc_d     = '0;
                    bit_cnt_d = '0;
                    state_d   = ST_RUN;
                end
            end
            ST_RUN: begin
                if (mplier_q[0]) begin
                    acc_d = acc_q + addend;
                end
                mplier_d  = mplier_q >> 1;
                bit_cnt_d = bit_cnt_q + 1'b1;
                if (bit_cnt_q == LAST_BIT) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                product_d = acc_q;
                done_d    = 1'b1;
                state_d   = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: state updates use non-blocking assignments so every register
        // samples the pre-edge values, independent of statement order.
        if (reset) begin
            state_q   <= ST_IDLE;
            mcand_q   <= '0;
            mplier_q  <= '0;
            acc_q     <= '0;
            product_q <= '0;
            bit_cnt_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            acc_q     <= acc_d;
            product_q <= product_d;
            bit_cnt_q <= bit_cnt_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign product = product_q;

`ifdef GPIOEMU_MULT_OPCNT_EN
    logic [31:0] op_count_q, op_count_d;

    // Counts in the DONE state so the new value appears alongside done.
    always_comb begin
        op_count_d = op_count_q;
        if (state_q == ST_DONE) begin
            op_count_d = op_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            op_count_q <= '0;
        end else begin
            op_count_q <= op_count_d;
        end
    end

    assign op_count = op_count_q;
`else
    assign op_count = 32'd0;
`endif

endmodule

// File: tb/tb_gpioemu_mult.sv
// Self-checking bench for gpioemu_mult: directed and random operations
// compared against an arithmetic reference product and operation count.
module tb_gpioemu_mult;

    localparam int W = 24;
`ifdef GPIOEMU_MULT_OPCNT_EN
    localparam bit OPCNT_EN = 1'b1;
`else
    localparam bit OPCNT_EN = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           reset;
    logic           start;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic           busy;
    logic           done;
    logic [2*W-1:0] product;
    logic [31:0]    op_count;

    int n_tests  = 0;
    int n_failed = 0;
    int ops_model = 0;

    gpioemu_mult #(.WIDTH(W)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .product  (product),
        .op_count (op_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] exp_count();
        return OPCNT_EN ? 64'(ops_model) : 64'd0;
    endfunction

    // mode 0: plain operation; 1: second start with new operands at t0+5;
    // 2: reset asserted on edge t0+10.
    task automatic do_op(input string tag, input logic [W-1:0] av,
                         input logic [W-1:0] bv, input int mode);
        logic [2*W-1:0] exp_p;
        int done_cnt;
        int lat;
        int busy_bad;
        bit exp_busy;
        exp_p    = 48'(av) * 48'(bv);
        done_cnt = 0;
        lat      = -1;
        busy_bad = 0;
        @(negedge clk);
        a = av; b = bv; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        a = W'($urandom);
        b = W'($urandom);
        for (int k = 1; k <= W + 8; k++) begin
            @(posedge clk);
            #1;
            exp_busy = (k <= W) && !(mode == 2 && k >= 10);
            if (busy !== exp_busy) busy_bad++;
            if (done === 1'b1) begin
                done_cnt++;
                lat = k;
            end
            if (mode == 2 && k == 10) begin
                reset = 1'b0;
                ops_model = 0;
                check({tag, " rst product"}, 64'(product), 64'd0);
                check({tag, " rst op_count"}, 64'(op_count), 64'd0);
            end
            if (mode == 1 && k == 4) begin
                a = W'($urandom); b = W'($urandom); start = 1'b1;
            end
            if (mode == 1 && k == 5) start = 1'b0;
            if (mode == 2 && k == 9) reset = 1'b1;
        end
        check({tag, " busy profile errors"}, 64'(busy_bad), 64'd0);
        if (mode == 2) begin
            check({tag, " done pulses"}, 64'(done_cnt), 64'd0);
        end else begin
            ops_model++;
            check({tag, " done pulses"}, 64'(done_cnt), 64'd1);
            check({tag, " latency"}, 64'(lat), 64'(W + 1));
            check({tag, " product"}, 64'(product), 64'(exp_p));
            check({tag, " op_count"}, 64'(op_count), exp_count());
        end
    endtask

    // start held high: second operation accepted on the IDLE edge after done.
    task automatic held_start(input logic [W-1:0] av, input logic [W-1:0] bv);
        int dones[$];
        @(negedge clk);
        a = av; b = bv; start = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= 2 * W + 8; k++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) dones.push_back(k);
            if (k == 2 * W + 3) start = 1'b0;
        end
        ops_model += 2;
        check("held done count", 64'(dones.size()), 64'd2);
        if (dones.size() == 2) begin
            check("held first latency", 64'(dones[0]), 64'(W + 1));
            check("held second latency", 64'(dones[1]), 64'(2 * W + 3));
        end
        check("held product", 64'(product), 64'(48'(av) * 48'(bv)));
        check("held op_count", 64'(op_count), exp_count());
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; a = '0; b = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset busy", 64'(busy), 64'd0);
        check("reset done", 64'(done), 64'd0);
        check("reset product", 64'(product), 64'd0);
        check("reset op_count", 64'(op_count), 64'd0);
        reset = 1'b0;

        do_op("basic", 24'h002137, 24'h000125, 0);
        check("basic literal", 64'(product), 64'h00000000_2603F3);
        do_op("max", 24'hFFFFFF, 24'hFFFFFF, 0);
        check("max literal", 64'(product), 64'hFFFFFE000001);
        do_op("zero", 24'h000000, 24'hF3EF67, 0);
        do_op("busy start", 24'h00ABCD, 24'h001234, 1);
        do_op("reset mid", 24'h123456, 24'h654321, 2);
        do_op("after reset", 24'h800001, 24'h000003, 0);
        held_start(24'h0F0F0F, 24'hF0F0F0);
        for (int i = 0; i < 20; i++) begin
            do_op($sformatf("rand%0d", i), W'($urandom), W'($urandom), 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
        $finish;
    end

endmodule

// File: doc/gpioemu_mult.md
# gpioemu_mult

Iterative unsigned shift-add multiplier core sitting directly downstream of the gpioemu register file. gpioemu latches operand A1 and, on a write to A2, pulses `start`; this block computes the product over WIDTH cycles and returns it with status and an operation count. gpioemu maps the results onto its W/L result registers, B status register and operation-counter register.

## Interface
- `WIDTH`, 24: operand width in bits; product is 2*WIDTH bits.
- `clk`  in  1  rising-edge clock, the single clock.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle request; accepted only when not busy.
- `a`  in  WIDTH  multiplicand (A1), sampled on the accepting edge.
- `b`  in  WIDTH  multiplier (A2), sampled on the accepting edge.
- `busy`  out  1  high while an operation is in progress.
- `done`  out  1  one-cycle pulse when `product` becomes valid.
- `product`  out  2*WIDTH  result, held until the next accepted start or reset.
- `op_count`  out  32  completed-operation counter (see Configuration).

## Operation
- States: IDLE, RUN, DONE.
- IDLE: `start`=1 loads `a` into the multiplicand register, `b` into the multiplier shift register, clears the accumulator and bit counter, and moves to RUN.
- RUN: each cycle, if the multiplier LSB is 1, add the multiplicand shifted by the bit index into the 2*WIDTH accumulator. Shift the multiplier right and increment the bit counter. After WIDTH iterations move to DONE.
- DONE: copy the accumulator to `product`, pulse `done`, increment `op_count`, and return to IDLE.
- Arithmetic: unsigned only, with no truncation. The accumulator is 2*WIDTH bits and cannot overflow.
- Latency is fixed at WIDTH cycles; zero operands take no early exit.
- `start` while busy (RUN) is ignored; operands are not resampled and no queueing occurs.
- `start` in the DONE cycle is accepted on the following IDLE cycle only if still asserted. Back-to-back operations need `start` held or re-pulsed.
- `a` and `b` may change freely after acceptance.
- Reset (any state, including mid-RUN): state goes to IDLE, the accumulator, `product` and `op_count` clear, and no `done` is emitted for the aborted operation.

## Timing
- Reset values: `busy`=0, `done`=0, `product`=0, `op_count`=0.
- `start` is sampled at edge t0 in IDLE.
- `busy`=1 in cycles t0+1 through t0+WIDTH.
- `done`=1 and `busy`=0 in cycle t0+WIDTH+1. `product` is valid from this cycle onward.
- Total start-to-done latency is WIDTH+1 cycles (25 for WIDTH=24).
- `op_count` is updated in the same cycle as `done` and wraps from 0xFFFFFFFF to 0.
- All outputs are registered; there are no combinational input-to-output paths.

## Configuration
- Macro: `GPIOEMU_MULT_OPCNT_EN`.
- Defined: the 32-bit operation counter is implemented as described above.
- Undefined: no counter flops are built, and `op_count` is tied to 0 permanently. All other behaviour is unchanged.

## Structure
- Shared package `gpioemu_pkg` holds:
  - the `WIDTH` default constant;
  - the state enum (IDLE/RUN/DONE);
  - the gpioemu register offsets: A1 0x430, A2 0x438, W 0x440, L 0x448, B 0x450, counter 0x458.
- No sub-module is needed. The datapath and FSM live in a single module, with the counter inside the `GPIOEMU_MULT_OPCNT_EN` guard.

## Test plan
- **Basic product:** a=0x002137, b=0x000125, start -> `done` at t0+25, product=0x000000_2603F3, op_count=1.
- **Maximum operands:** a=b=0xFFFFFF -> product=0xFFFFFE000001 after 25 cycles with no overflow; op_count increments.
- **Zero operand:** a=0, b=0xF3EF67 -> product=0 with full 25-cycle latency and a single `done` pulse.
- **Start while busy:** second start with new operands at t0+5 -> ignored; the first result is delivered, exactly one `done` occurs, and op_count increments by 1.
- **Reset mid-operation:** reset at t0+10 -> busy=0, product=0, op_count=0, and no `done`. A following start completes normally.
- **Counter macro:** with `GPIOEMU_MULT_OPCNT_EN` undefined -> op_count stays 0 across 3 operations while products remain correct.
